serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Parametrised multi-cycle adder built from a chain of full-adder slices.
//   Processes BITS_PER_CYC operand bits per clock, LSB first, with a rippled carry flop.
//   Uses a start/busy/done handshake. Serves as the area-lean arithmetic unit for datapaths
//   that do not need a single-cycle WIDTH-bit adder.
// PARAMETERS
//   WIDTH         8   operand/result width in bits, >= 2
//   BITS_PER_CYC  1   bits added per RUN cycle; must divide WIDTH; N = WIDTH/BITS_PER_CYC steps
// PORTS
//   clk       in   1      rising-edge clock; the only clock
//   rst       in   1      synchronous active-high reset
//   start     in   1      request; sampled only while busy=0
//   a         in   WIDTH  operand A; captured when start is accepted
//   b         in   WIDTH  operand B; captured when start is accepted
//   cin       in   1      carry-in; captured when start is accepted
//   sub       in   1      1 = A-B (SERIAL_ADDER_SUB_EN builds only); captured with operands
//   busy      out  1      high in RUN and DONE states
//   done      out  1      one-cycle pulse: result valid
//   sum       out  WIDTH  result register
//   carry     out  1      carry out of MSB (in subtract mode: 1 = no borrow)
//   overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
// - Reset, synchronous, highest priority:
//   - state=IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, internal shift regs and step counter cleared.
//   - Reset mid-RUN aborts the operation; no done pulse is produced.
// - FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 loads op_a<=a, op_b<=b, cy<=cin, step<=0, then goes to RUN. start=0 stays IDLE.
//   - RUN: each cycle takes the low BITS_PER_CYC bits of op_a/op_b through a full-adder chain seeded with cy.
//     - The result bits are shifted into the MSB end of the work register; op_a/op_b shift right by BITS_PER_CYC.
//     - cy <= chain carry-out; step <= step+1.
//     - On step==N-1: sum<=completed work register, carry<=final carry-out, overflow<=c_msb_in ^ c_msb_out.
//       The FSM then goes to DONE.
//   - DONE: done=1 for exactly this cycle, then IDLE unconditionally.
// - Handshake:
//   - start is accepted only in IDLE; start in RUN/DONE is ignored (not queued).
//   - Operand inputs may change freely after acceptance.
// - Latency: start accepted in cycle T -> done=1 in cycle T+N+1. Issue interval is N+2 cycles.
// - Outputs:
//   - sum/carry/overflow update only on the final RUN step.
//   - They hold until the next completion or reset; intermediate partial sums are never visible on sum.
// - Arithmetic: result = (a + b + cin) mod 2^WIDTH; carry = bit WIDTH of the full sum.
// - Counter: step is ceil(log2(N))+1 bits wide. When N=1 (BITS_PER_CYC==WIDTH), RUN lasts one cycle.
// - Simultaneous rst & start: rst wins; start ignored.
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN defined:
//     - On acceptance with sub=1: op_b <= ~b and cy <= 1; cin is ignored.
//     - The result is a-b mod 2^WIDTH. carry=0 indicates borrow. overflow is signed a-b overflow.
//   SERIAL_ADDER_SUB_EN undefined:
//     - sub is ignored and no inversion logic is built; always add.
// TESTING
//   1 W=8,BPC=1: a=8'hFF,b=8'h01,cin=0,start -> done at T+9, sum=8'h00, carry=1, overflow=0
//   2 W=8,BPC=1: a=8'h7F,b=8'h01,cin=1 -> sum=8'h81, carry=0, overflow=1; busy high T+1..T+9
//   3 start=1 with a=8'h10,b=8'h20 pulsed during RUN of op (8'h03+8'h04) -> ignored, sum=8'h07, single done
//   4 rst asserted on 4th RUN cycle -> next cycle busy=0, done=0, sum=0; no done pulse;
//     a new start then completes normally
//   5 SUB_EN, W=8: sub=1,a=8'h05,b=8'h07 -> sum=8'hFE, carry=0, overflow=0;
//     a=8'h80,b=8'h01 -> sum=8'h7F, overflow=1
//   6 W=16,BPC=4: 1000 random a,b,cin, start held high -> each done at T+5,
//     sum/carry == {carry,sum} model of a+b+cin; done pulses exactly 6 cycles apart

Source files
------------

// File: rtl/serial_adder_if.sv
// ============================================================================
// serial_adder_if : start/busy/done handshake and operand/result bundle
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, carry, overflow
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : multi-cycle LSB-first adder, BITS_PER_CYC bits per clock
// Optional subtract mode built when SERIAL_ADDER_SUB_EN is defined.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH        = 8,
  parameter int BITS_PER_CYC = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  serial_adder_if.slave  bus
);

  localparam int N      = WIDTH / BITS_PER_CYC;
  localparam int STEP_W = $clog2(N) + 1;
  localparam int SHIFT  = WIDTH - BITS_PER_CYC;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic [WIDTH-1:0]      work;
  logic                  cy;
  logic [STEP_W-1:0]     step;

  logic [BITS_PER_CYC:0]   chain_c;
  logic [BITS_PER_CYC-1:0] chain_s;
  logic [WIDTH-1:0]        work_next;
  logic [WIDTH-1:0]        load_b;
  logic                    load_cy;

  assign chain_c[0] = cy;

  generate
    for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_slice
      assign chain_s[i]   = op_a[i] ^ op_b[i] ^ chain_c[i];
      assign chain_c[i+1] = (op_a[i] & op_b[i]) | (chain_c[i] & (op_a[i] ^ op_b[i]));
    end
  endgenerate

  // New result bits enter at the MSB end; after N steps bit 0 has reached position 0.
  assign work_next = (work >> BITS_PER_CYC) | (WIDTH'(chain_s) << SHIFT);

`ifdef SERIAL_ADDER_SUB_EN
  assign load_b  = bus.sub ? ~bus.b : bus.b;
  assign load_cy = bus.sub ? 1'b1   : bus.cin;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign load_b     = bus.b;
  assign load_cy    = bus.cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op_a         <= '0;
      op_b         <= '0;
      work         <= '0;
      cy           <= 1'b0;
      step         <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a     <= bus.a;
            op_b     <= load_b;
            cy       <= load_cy;
            work     <= '0;
            step     <= '0;
            bus.busy <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          op_a <= op_a >> BITS_PER_CYC;
          op_b <= op_b >> BITS_PER_CYC;
          cy   <= chain_c[BITS_PER_CYC];
          work <= work_next;
          step <= step + 1'b1;
          // On the final step the top slice of the chain is the operand MSB.
          if (step == LAST_STEP) begin
            bus.sum      <= work_next;
            bus.carry    <= chain_c[BITS_PER_CYC];
            bus.overflow <= chain_c[BITS_PER_CYC-1] ^ chain_c[BITS_PER_CYC];
            bus.done     <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : directed vectors for an 8x1 instance, random stream for 16x4
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(16)) if16 ();

  serial_adder #(.WIDTH(8), .BITS_PER_CYC(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  serial_adder #(.WIDTH(16), .BITS_PER_CYC(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       carry;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic [7:0] e_sum, input logic e_carry,
                         input logic e_ov);
    int lat;
    if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    if8.a = ~a; if8.b = ~b; if8.cin = ~cin;
    lat = 1;
    while (!if8.done && lat < 20) begin
      chk("busy_in_run", {31'b0, if8.busy}, 32'd1);
      tick();
      lat++;
    end
    chk("latency", lat, 32'd9);
    chk("busy_at_done", {31'b0, if8.busy}, 32'd1);
    chk("sum", {24'b0, if8.sum}, {24'b0, e_sum});
    chk("carry", {31'b0, if8.carry}, {31'b0, e_carry});
    chk("overflow", {31'b0, if8.overflow}, {31'b0, e_ov});
    tick();
    chk("done_one_cycle", {31'b0, if8.done}, 32'd0);
    chk("busy_after_done", {31'b0, if8.busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    logic [7:0]  sum_at_done;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;
    logic        e_ov16;

    //                a      b      cin   sub   sum    carry ov
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
    vecs[6] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
`else
    vecs[6] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
`endif

    rst = 1'b1;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.sub = 1'b0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0;
    tick();
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    rst = 1'b0;
    chk("rst_busy", {31'b0, if8.busy}, 32'd0);
    chk("rst_done", {31'b0, if8.done}, 32'd0);
    chk("rst_sum", {24'b0, if8.sum}, 32'd0);
    chk("rst_carry", {31'b0, if8.carry}, 32'd0);
    chk("rst_overflow", {31'b0, if8.overflow}, 32'd0);
    chk("rst_busy16", {31'b0, if16.busy}, 32'd0);
    tick();
    chk("rst_start_ignored", {31'b0, if8.busy}, 32'd0);

    for (int i = 0; i < 8; i++)
      run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
              vecs[i].sum, vecs[i].carry, vecs[i].ov);

    // start pulsed during RUN must be dropped, not queued
    if8.a = 8'h03; if8.b = 8'h04; if8.cin = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    ndone = 0;
    sum_at_done = 8'hXX;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin if8.a = 8'h10; if8.b = 8'h20; if8.start = 1'b1; end
      if (c == 4) if8.start = 1'b0;
      tick();
      if (if8.done) begin
        ndone++;
        sum_at_done = if8.sum;
      end
    end
    chk("ignored_start_done_count", ndone, 32'd1);
    chk("ignored_start_sum", {24'b0, sum_at_done}, 32'h07);

    // reset on the 4th RUN cycle aborts the operation
    if8.a = 8'h12; if8.b = 8'h34; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'b0, if8.busy}, 32'd0);
    chk("abort_done", {31'b0, if8.done}, 32'd0);
    chk("abort_sum", {24'b0, if8.sum}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (if8.done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    run_op8(8'h21, 8'h43, 1'b1, 1'b0, 8'h65, 1'b0, 1'b0);

    // 16-bit, 4 bits/cycle: start held high, operands replaced every issue slot
    if16.start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if16.a = ra; if16.b = rb; if16.cin = rc;
      full   = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      e_ov16 = (ra[15] == rb[15]) && (full[15] != ra[15]);
      tick();
      if16.a = 16'($urandom); if16.b = 16'($urandom); if16.cin = 1'($urandom);
      ndone = 0;
      for (int c = 0; c < 3; c++) begin
        tick();
        if (if16.done) ndone++;
      end
      tick();
      chk("w16_done_early", ndone, 32'd0);
      chk("w16_done", {31'b0, if16.done}, 32'd1);
      chk("w16_sum", {16'b0, if16.sum}, {16'b0, full[15:0]});
      chk("w16_carry", {31'b0, if16.carry}, {31'b0, full[16]});
      chk("w16_overflow", {31'b0, if16.overflow}, {31'b0, e_ov16});
      tick();
      chk("w16_done_pulse", {31'b0, if16.done}, 32'd0);
    end
    if16.start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
